// File: rtl/fpga_cfg_pkg.sv
// ----------------------------------------------------------------------------
// fpga_cfg_pkg
//   Shared definitions for the fabric configuration loader.
//   - cfg_state_t : loader state machine encoding
//   - CRC16_POLY  : CRC-16-CCITT polynomial used to protect the bitstream
//   - CRC16_INIT  : CRC register value at the start of every load
//   - crc16_step  : one bit of the MSB-first CRC register update
//   The CRC items are only used when BITSTREAM_CRC_EN is defined.
// ----------------------------------------------------------------------------
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SHIFT  = 3'd2,
        FINISH = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } cfg_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Feedback is the outgoing MSB xor the new data bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        crc16_step = {crc[14:0], 1'b0} ^ (((crc[15] ^ bit_in) == 1'b1) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/prog_clk_divider.sv
// ----------------------------------------------------------------------------
// prog_clk_divider
//   Generates the configuration shift clock from the system clock. While
//   enabled, prog_clk toggles every CLK_DIV clk cycles, starting low. When
//   disabled the divider is cleared and prog_clk is held low, so the chain
//   never sees a clock edge outside a shift.
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   enable   in   run the divider (loader in SHIFT)
//   prog_clk out  registered shift clock (glitch-free)
//   rise     out  strobe: prog_clk goes high on the next clk edge
//   fall     out  strobe: prog_clk goes low on the next clk edge
// ----------------------------------------------------------------------------
module prog_clk_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic prog_clk,
    output logic rise,
    output logic fall
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          terminal;

    // Strobes are decoded one cycle ahead so the loader updates its
    // counters on the same edge that moves prog_clk.
    assign terminal = enable && (div_cnt == DW'(CLK_DIV - 1));
    assign rise     = terminal && !prog_clk;
    assign fall     = terminal && prog_clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            prog_clk <= 1'b0;
        end else if (!enable) begin
            div_cnt  <= '0;
            prog_clk <= 1'b0;
        end else if (terminal) begin
            div_cnt  <= '0;
            prog_clk <= ~prog_clk;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bitstream_loader.sv
// ----------------------------------------------------------------------------
// bitstream_loader
//   Programming controller for the fabric configuration chain. Takes a byte
//   stream, shifts it LSB-first onto prog_in with a generated prog_clk and
//   keeps prog_en high for exactly CHAIN_LEN shifts.
//   Optional feature macro: BITSTREAM_CRC_EN -- two trailing CRC-16-CCITT
//   bytes (high byte first) are fetched after the chain data and compared
//   against a CRC of the shifted bits; a mismatch ends in ERROR with the
//   fabric kept in programming mode.
// Ports
//   clk, rst_n           system clock, asynchronous active-low reset
//   start                one-cycle pulse, begins a load when not busy
//   cfg_data/valid/ready configuration byte stream (valid/ready handshake)
//   prog_in/clk/en       serial chain data, shift clock, programming mode
//   prog_out_fb          chain tail, sticky debug only (CRC build)
//   busy, done, error    load status; done/error held until next start
// ----------------------------------------------------------------------------
module bitstream_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 25000,
    parameter int CLK_DIV   = 2,
    parameter int CNT_W     = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       prog_in,
    output logic       prog_clk,
    output logic       prog_en,
    input  logic       prog_out_fb,
    output logic       busy,
    output logic       done,
    output logic       error
);

`ifdef BITSTREAM_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    cfg_state_t       state, state_nxt;
    logic [7:0]       sreg;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] bit_cnt;
    logic             shift_en, rise, fall;
    logic             start_accept, handshake, chain_full;
    logic             fetch_crc, crc_last, crc_ok;
    logic             unused_fb;

    assign shift_en     = (state == SHIFT);
    assign start_accept = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign handshake    = cfg_valid && cfg_ready;
    assign chain_full   = (bit_cnt == CNT_W'(CHAIN_LEN));

    prog_clk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (shift_en),
        .prog_clk (prog_clk),
        .rise     (rise),
        .fall     (fall)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A bit is complete on its falling prog_clk edge; the
    // bit counter already includes it there, so a mid-byte chain end drops
    // the remaining bits of the current byte.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (cfg_valid) begin
                    if (!fetch_crc) begin
                        state_nxt = SHIFT;
                    end else if (crc_last) begin
                        state_nxt = FINISH;
                    end
                end
            end
            SHIFT: begin
                if (fall) begin
                    if (chain_full) begin
                        state_nxt = CRC_EN ? FETCH : FINISH;
                    end else if (bit_idx == 3'd7) begin
                        state_nxt = FETCH;
                    end
                end
            end
            FINISH: begin
                state_nxt = crc_ok ? DONE : ERROR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Moore outputs. prog_en stays high in ERROR so a failed load leaves the
    // routing inert rather than half-configured.
    always_comb begin
        cfg_ready = (state == FETCH);
        busy      = (state == FETCH) || (state == SHIFT) || (state == FINISH);
        prog_en   = busy || (state == ERROR);
        done      = (state == DONE);
        prog_in   = shift_en ? sreg[bit_idx] : 1'b0;
    end

    // Shift datapath: byte capture, bit position within the byte, and the
    // chain-wide shift count advanced on every rising prog_clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            bit_idx <= '0;
            bit_cnt <= '0;
        end else begin
            if (start_accept) begin
                bit_cnt <= '0;
            end else if (rise) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (handshake && !fetch_crc) begin
                sreg    <= cfg_data;
                bit_idx <= '0;
            end else if (fall) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

`ifdef BITSTREAM_CRC_EN
    logic [15:0] crc_calc;
    logic [15:0] crc_rx;
    logic        crc_phase;
    logic        crc_byte;
    logic        fb_sticky;

    // CRC over the shifted data bits, plus capture of the two trailing CRC
    // bytes (first byte received is the high byte).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_calc  <= CRC16_INIT;
            crc_rx    <= '0;
            crc_phase <= 1'b0;
            crc_byte  <= 1'b0;
            fb_sticky <= 1'b0;
        end else if (start_accept) begin
            crc_calc  <= CRC16_INIT;
            crc_rx    <= '0;
            crc_phase <= 1'b0;
            crc_byte  <= 1'b0;
            fb_sticky <= 1'b0;
        end else begin
            if (rise) begin
                crc_calc  <= crc16_step(crc_calc, prog_in);
                fb_sticky <= fb_sticky | prog_out_fb;
            end
            if (shift_en && fall && chain_full) begin
                crc_phase <= 1'b1;
            end
            if (handshake && crc_phase) begin
                crc_rx   <= {crc_rx[7:0], cfg_data};
                crc_byte <= 1'b1;
            end
        end
    end

    assign fetch_crc = crc_phase;
    assign crc_last  = crc_byte;
    assign crc_ok    = (crc_rx == crc_calc);
    assign error     = (state == ERROR);
    assign unused_fb = fb_sticky;
`else
    assign fetch_crc = 1'b0;
    assign crc_last  = 1'b0;
    assign crc_ok    = 1'b1;
    assign error     = 1'b0;
    assign unused_fb = prog_out_fb;
`endif

endmodule

// File: tb/tb_bitstream_loader.sv
// ----------------------------------------------------------------------------
// tb_bitstream_loader
//   Two loader instances: dut_a (CHAIN_LEN=16, CLK_DIV=1) and dut_b
//   (CHAIN_LEN=12, CLK_DIV=2). Expected chain bits are queued as bytes are
//   issued; a monitor pops them on every observed prog_clk rise. With
//   BITSTREAM_CRC_EN defined the bench appends CRC bytes to every load.
// ----------------------------------------------------------------------------
module tb_bitstream_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start_a = 1'b0, valid_a = 1'b0, fb_a = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       ready_a, pin_a, pclk_a, pen_a, busy_a, done_a, error_a;

    logic       start_b = 1'b0, valid_b = 1'b0, fb_b = 1'b0;
    logic [7:0] data_b = 8'h00;
    logic       ready_b, pin_b, pclk_b, pen_b, busy_b, done_b, error_b;

    int         checks = 0;
    int         errors = 0;

    logic       exp_a[$];
    logic       exp_b[$];
    int         rise_a = 0, rise_b = 0;
    logic [15:0] fab_a = 16'h0, fab_b = 16'h0;
    logic       pclk_a_prev = 1'b0, pclk_b_prev = 1'b0;
    logic [15:0] crc_a = 16'hFFFF, crc_b = 16'hFFFF;

    always #5 clk = ~clk;

    bitstream_loader #(.CHAIN_LEN(16), .CLK_DIV(1), .CNT_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cfg_data(data_a),
        .cfg_valid(valid_a), .cfg_ready(ready_a), .prog_in(pin_a),
        .prog_clk(pclk_a), .prog_en(pen_a), .prog_out_fb(fb_a),
        .busy(busy_a), .done(done_a), .error(error_a)
    );

    bitstream_loader #(.CHAIN_LEN(12), .CLK_DIV(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cfg_data(data_b),
        .cfg_valid(valid_b), .cfg_ready(ready_b), .prog_in(pin_b),
        .prog_clk(pclk_b), .prog_en(pen_b), .prog_out_fb(fb_b),
        .busy(busy_b), .done(done_b), .error(error_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        logic fbk;
        fbk = c[15] ^ b;
        crc_bit = {c[14:0], 1'b0} ^ (fbk ? 16'h1021 : 16'h0000);
    endfunction

    // Monitor: on each prog_clk rise, pop the expected chain bit, check the
    // programming enable and clock the bit into a fabric chain model.
    always @(negedge clk) begin
        logic e;
        if (pclk_a && !pclk_a_prev) begin
            rise_a++;
            fab_a = {pin_a, fab_a[15:1]};
            checkOutput("prog_en_at_rise_a", {31'd0, pen_a}, 32'd1);
            if (exp_a.size() == 0) begin
                checkOutput("unexpected_rise_a", 32'd1, 32'd0);
            end else begin
                e = exp_a.pop_front();
                checkOutput("prog_in_a", {31'd0, pin_a}, {31'd0, e});
            end
        end
        if (pclk_b && !pclk_b_prev) begin
            rise_b++;
            fab_b = {pin_b, fab_b[15:1]};
            checkOutput("prog_en_at_rise_b", {31'd0, pen_b}, 32'd1);
            if (exp_b.size() == 0) begin
                checkOutput("unexpected_rise_b", 32'd1, 32'd0);
            end else begin
                e = exp_b.pop_front();
                checkOutput("prog_in_b", {31'd0, pin_b}, {31'd0, e});
            end
        end
        pclk_a_prev = pclk_a;
        pclk_b_prev = pclk_b;
    end

    task automatic send_byte(input int d, input logic [7:0] b);
        int waited;
        logic rdy;
        waited = 0;
        @(negedge clk);
        if (d == 0) begin data_a = b; valid_a = 1'b1; end
        else        begin data_b = b; valid_b = 1'b1; end
        rdy = (d == 0) ? ready_a : ready_b;
        while (!rdy && waited < 500) begin
            @(negedge clk);
            waited++;
            rdy = (d == 0) ? ready_a : ready_b;
        end
        if (!rdy) begin
            checkOutput("handshake_timeout", 32'd1, 32'd0);
        end
        @(posedge clk);
        #1;
        if (d == 0) valid_a = 1'b0;
        else        valid_b = 1'b0;
    endtask

    // Queue the chain bits this byte is expected to produce, then send it.
    task automatic applyStimulus(input int d, input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (d == 0) begin exp_a.push_back(b[i]); crc_a = crc_bit(crc_a, b[i]); end
            else        begin exp_b.push_back(b[i]); crc_b = crc_bit(crc_b, b[i]); end
        end
        send_byte(d, b);
    endtask

    task automatic send_crc(input int d, input bit corrupt);
        logic [15:0] c;
        c = (d == 0) ? crc_a : crc_b;
        if (corrupt) c = c ^ 16'h0100;
        send_byte(d, c[15:8]);
        send_byte(d, c[7:0]);
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk);
        if (d == 0) begin start_a = 1'b1; crc_a = 16'hFFFF; rise_a = 0; fab_a = 16'h0; end
        else        begin start_b = 1'b1; crc_b = 16'hFFFF; rise_b = 0; fab_b = 16'h0; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic finish_load(input int d, input bit corrupt);
`ifdef BITSTREAM_CRC_EN
        send_crc(d, corrupt);
`else
        if (corrupt) $display("[TB] corrupt request ignored without CRC build");
`endif
    endtask

    task automatic wait_done(input int d, input string name);
        int n;
        logic fin;
        n = 0;
        fin = (d == 0) ? (done_a | error_a) : (done_b | error_b);
        while (!fin && n < 2000) begin
            @(negedge clk);
            n++;
            fin = (d == 0) ? (done_a | error_a) : (done_b | error_b);
        end
        if (!fin) checkOutput(name, 32'd0, 32'd1);
    endtask

    initial begin
        int stall_clk_seen;
        int stall_en_low;
        int n;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_prog_en", {31'd0, pen_a}, 32'd0);
        checkOutput("rst_prog_clk", {31'd0, pclk_a}, 32'd0);
        checkOutput("rst_prog_in", {31'd0, pin_a}, 32'd0);
        checkOutput("rst_cfg_ready", {31'd0, ready_a}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy_a}, 32'd0);
        checkOutput("rst_done", {31'd0, done_a}, 32'd0);
        checkOutput("rst_error", {31'd0, error_a}, 32'd0);
        rst_n = 1'b1;

        // Basic 16-bit load.
        $display("[TB] load 0xA5,0x3C into 16-bit chain");
        pulse_start(0);
        checkOutput("start_busy", {31'd0, busy_a}, 32'd1);
        checkOutput("start_prog_en", {31'd0, pen_a}, 32'd1);
        checkOutput("start_ready", {31'd0, ready_a}, 32'd1);
        applyStimulus(0, 8'hA5, 8);
        applyStimulus(0, 8'h3C, 8);
        finish_load(0, 1'b0);
        wait_done(0, "done_timeout_basic");
        @(negedge clk);
        checkOutput("basic_done", {31'd0, done_a}, 32'd1);
        checkOutput("basic_error", {31'd0, error_a}, 32'd0);
        checkOutput("basic_prog_en", {31'd0, pen_a}, 32'd0);
        checkOutput("basic_busy", {31'd0, busy_a}, 32'd0);
        checkOutput("basic_rises", rise_a, 32'd16);
        checkOutput("basic_fabric", {16'd0, fab_a}, 32'h3CA5);
        checkOutput("basic_queue_empty", exp_a.size(), 32'd0);

        // 12-bit chain, second byte truncated, start pulsed while busy.
        $display("[TB] load 0xFF,0x0F into 12-bit chain");
        pulse_start(1);
        applyStimulus(1, 8'hFF, 8);
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        applyStimulus(1, 8'h0F, 4);
        finish_load(1, 1'b0);
        wait_done(1, "done_timeout_short");
        @(negedge clk);
        checkOutput("short_done", {31'd0, done_b}, 32'd1);
        checkOutput("short_rises", rise_b, 32'd12);
        checkOutput("short_fabric", {20'd0, fab_b[15:4]}, 32'hFFF);
        checkOutput("short_prog_en", {31'd0, pen_b}, 32'd0);
        checkOutput("short_queue_empty", exp_b.size(), 32'd0);

        // Stream stall between bytes.
        $display("[TB] stall stream for 20 cycles mid-load");
        pulse_start(0);
        applyStimulus(0, 8'h96, 8);
        n = 0;
        while (!ready_a && n < 100) begin @(negedge clk); n++; end
        stall_clk_seen = 0;
        stall_en_low = 0;
        repeat (20) begin
            @(negedge clk);
            if (pclk_a) stall_clk_seen++;
            if (!pen_a) stall_en_low++;
        end
        checkOutput("stall_prog_clk_toggles", stall_clk_seen, 32'd0);
        checkOutput("stall_prog_en_drops", stall_en_low, 32'd0);
        applyStimulus(0, 8'h69, 8);
        finish_load(0, 1'b0);
        wait_done(0, "done_timeout_stall");
        @(negedge clk);
        checkOutput("stall_done", {31'd0, done_a}, 32'd1);
        checkOutput("stall_rises", rise_a, 32'd16);
        checkOutput("stall_fabric", {16'd0, fab_a}, 32'h6996);

        // Asynchronous reset during SHIFT.
        $display("[TB] reset during shift");
        pulse_start(0);
        applyStimulus(0, 8'hC3, 8);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_prog_en", {31'd0, pen_a}, 32'd0);
        checkOutput("midrst_prog_clk", {31'd0, pclk_a}, 32'd0);
        checkOutput("midrst_prog_in", {31'd0, pin_a}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy_a}, 32'd0);
        checkOutput("midrst_ready", {31'd0, ready_a}, 32'd0);
        checkOutput("midrst_done", {31'd0, done_a}, 32'd0);
        @(negedge clk);
        exp_a.delete();
        rst_n = 1'b1;
        pulse_start(0);
        applyStimulus(0, 8'hA5, 8);
        applyStimulus(0, 8'h3C, 8);
        finish_load(0, 1'b0);
        wait_done(0, "done_timeout_reload");
        @(negedge clk);
        checkOutput("reload_done", {31'd0, done_a}, 32'd1);
        checkOutput("reload_rises", rise_a, 32'd16);
        checkOutput("reload_fabric", {16'd0, fab_a}, 32'h3CA5);

`ifdef BITSTREAM_CRC_EN
        // Corrupted CRC byte.
        $display("[TB] load with corrupted CRC");
        pulse_start(0);
        applyStimulus(0, 8'hA5, 8);
        applyStimulus(0, 8'h3C, 8);
        finish_load(0, 1'b1);
        wait_done(0, "done_timeout_badcrc");
        @(negedge clk);
        checkOutput("badcrc_error", {31'd0, error_a}, 32'd1);
        checkOutput("badcrc_done", {31'd0, done_a}, 32'd0);
        checkOutput("badcrc_prog_en", {31'd0, pen_a}, 32'd1);
        checkOutput("badcrc_busy", {31'd0, busy_a}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
